// File: rtl/cdc_bridge_pkg.sv
// Shared constants for the CDC command bridge: opcodes, default status codes
// and the command FSM state encoding.
package cdc_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_PING  = 8'h03;

    localparam logic [7:0] ACK_CODE_DEF   = 8'hA5;
    localparam logic [7:0] ERR_CODE_DEF   = 8'hEE;
    localparam logic [7:0] BADOP_CODE_DEF = 8'hE1;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ADDR_H = 4'd1,
        ST_ADDR_L = 4'd2,
        ST_DATA_H = 4'd3,
        ST_DATA_L = 4'd4,
        ST_BUS    = 4'd5,
        ST_RSP_ST = 4'd6,
        ST_RSP_DH = 4'd7,
        ST_RSP_DL = 4'd8
    } state_t;

endpackage

// File: rtl/cdc_bridge_rsp.sv
// Response holding register for the CDC command bridge: loaded with 1 or 3
// bytes, presents them in order on a valid/ready byte stream.
module cdc_bridge_rsp (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [1:0]  load_cnt,
    input  logic [23:0] load_data,
    input  logic        in_ready,
    output logic [7:0]  in_data,
    output logic        in_valid,
    output logic        last
);

    logic [15:0] tail;
    logic [1:0]  cnt;

    // A byte leaves on in_valid & in_ready; in_data holds until then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_data  <= 8'h00;
            in_valid <= 1'b0;
            tail     <= 16'h0000;
            cnt      <= 2'd0;
        end else if (load) begin
            in_data  <= load_data[23:16];
            tail     <= load_data[15:0];
            cnt      <= load_cnt;
            in_valid <= (load_cnt != 2'd0);
        end else if (in_valid && in_ready) begin
            in_data  <= tail[15:8];
            tail     <= {tail[7:0], 8'h00};
            cnt      <= cnt - 2'd1;
            in_valid <= (cnt != 2'd1);
        end
    end

    assign last = (cnt == 2'd1);

endmodule

// File: rtl/cdc_cmd_bridge.sv
// Byte-stream command responder: host bytes in, one 16-bit bus access, status/data bytes out.
// Optional bus timeout is built only when BRIDGE_TIMEOUT_EN is defined.
module cdc_cmd_bridge
    import cdc_bridge_pkg::*;
#(
    parameter logic [7:0]  ACK_CODE       = ACK_CODE_DEF,
    parameter logic [7:0]  BADOP_CODE     = BADOP_CODE_DEF,
    parameter logic [7:0]  ERR_CODE       = ERR_CODE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  out_data_i,
    input  logic        out_valid_i,
    output logic        out_ready_o,
    output logic [7:0]  in_data_o,
    output logic        in_valid_o,
    input  logic        in_ready_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [15:0] bus_addr_o,
    output logic [15:0] bus_wdata_o,
    input  logic [15:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic [3:0]  dbg_state_o
);

    state_t      state;
    logic        out_fire;
    logic        in_fire;
    logic        rsp_load;
    logic [1:0]  rsp_cnt;
    logic [23:0] rsp_data;
    logic        rsp_last;

    assign out_fire    = out_valid_i & out_ready_o;
    assign in_fire     = in_valid_o & in_ready_i;
    assign dbg_state_o = state;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned T_LAST_I = TIMEOUT_CYCLES - 1;
    localparam logic [TW-1:0] T_LAST = T_LAST_I[TW-1:0];

    logic [TW-1:0] to_cnt;
    logic          to_hit;

    // Zero in every non-BUS cycle, so it starts from 0 on each BUS entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt <= '0;
        end else if (state != ST_BUS) begin
            to_cnt <= '0;
        end else if (!to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_hit = (to_cnt == T_LAST);
`endif

    // Response load decode; an ack on the terminal timeout count still wins.
    always_comb begin
        rsp_load = 1'b0;
        rsp_cnt  = 2'd1;
        rsp_data = {ACK_CODE, 16'h0000};
        case (state)
            ST_IDLE: begin
                if (out_fire && out_data_i != OP_WRITE && out_data_i != OP_READ) begin
                    rsp_load       = 1'b1;
                    rsp_data[23:16] = (out_data_i == OP_PING) ? ACK_CODE : BADOP_CODE;
                end
            end
            ST_BUS: begin
                if (bus_ack_i) begin
                    rsp_load = 1'b1;
                    if (!bus_we_o) begin
                        rsp_cnt  = 2'd3;
                        rsp_data = {ACK_CODE, bus_rdata_i};
                    end
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (to_hit) begin
                    rsp_load = 1'b1;
                    rsp_data = {ERR_CODE, 16'h0000};
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            out_ready_o <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 16'h0000;
            bus_wdata_o <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (out_fire) begin
                        if (out_data_i == OP_WRITE || out_data_i == OP_READ) begin
                            bus_we_o <= (out_data_i == OP_WRITE);
                            state    <= ST_ADDR_H;
                        end else begin
                            out_ready_o <= 1'b0;
                            state       <= ST_RSP_ST;
                        end
                    end else begin
                        out_ready_o <= 1'b1;
                    end
                end
                ST_ADDR_H: begin
                    if (out_fire) begin
                        bus_addr_o[15:8] <= out_data_i;
                        state            <= ST_ADDR_L;
                    end
                end
                ST_ADDR_L: begin
                    if (out_fire) begin
                        bus_addr_o[7:0] <= out_data_i;
                        if (bus_we_o) begin
                            state <= ST_DATA_H;
                        end else begin
                            out_ready_o <= 1'b0;
                            bus_req_o   <= 1'b1;
                            state       <= ST_BUS;
                        end
                    end
                end
                ST_DATA_H: begin
                    if (out_fire) begin
                        bus_wdata_o[15:8] <= out_data_i;
                        state             <= ST_DATA_L;
                    end
                end
                ST_DATA_L: begin
                    if (out_fire) begin
                        bus_wdata_o[7:0] <= out_data_i;
                        out_ready_o      <= 1'b0;
                        bus_req_o        <= 1'b1;
                        state            <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (rsp_load) begin
                        bus_req_o <= 1'b0;
                        state     <= ST_RSP_ST;
                    end
                end
                ST_RSP_ST: begin
                    if (in_fire) begin
                        if (rsp_last) begin
                            out_ready_o <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            state <= ST_RSP_DH;
                        end
                    end
                end
                ST_RSP_DH: begin
                    if (in_fire) state <= ST_RSP_DL;
                end
                ST_RSP_DL: begin
                    if (in_fire) begin
                        out_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_ready_o <= 1'b0;
                    bus_req_o   <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    cdc_bridge_rsp u_rsp (
        .clk       (clk_i),
        .rst       (rst_i),
        .load      (rsp_load),
        .load_cnt  (rsp_cnt),
        .load_data (rsp_data),
        .in_ready  (in_ready_i),
        .in_data   (in_data_o),
        .in_valid  (in_valid_o),
        .last      (rsp_last)
    );

endmodule

// File: tb/tb_cdc_cmd_bridge.sv
// Bench for cdc_cmd_bridge: directed scenarios plus random commands against a
// command-level reference model and a simple bus slave memory.
module tb_cdc_cmd_bridge;

    typedef logic [7:0] byte_q_t[$];

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  out_data = 8'h00;
    logic        out_valid = 1'b0;
    logic        out_ready;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready = 1'b0;
    logic        bus_req, bus_we;
    logic [15:0] bus_addr, bus_wdata;
    logic [15:0] resp_rdata = 16'h0000;
    logic        resp_ack = 1'b0;
    logic        spur_ack = 1'b0;
    logic [3:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    cdc_cmd_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .out_data_i  (out_data),
        .out_valid_i (out_valid),
        .out_ready_o (out_ready),
        .in_data_o   (in_data),
        .in_valid_o  (in_valid),
        .in_ready_i  (in_ready),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_rdata_i (resp_rdata),
        .bus_ack_i   (resp_ack | spur_ack),
        .dbg_state_o (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bus slave: acks after ack_delay request cycles (0 = never) or when forced
    function automatic logic [15:0] mem_init(input logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    logic [15:0] slave_mem [logic [15:0]];
    logic [32:0] bus_log[$];
    int          ack_delay = 1;
    bit          force_ack = 0;
    int          cur_len = 0, last_len = 0, req_total = 0, stab_err = 0;
    logic [32:0] held = '0;

    initial begin
        forever begin
            @(negedge clk);
            resp_ack   = 1'b0;
            resp_rdata = 16'($urandom);
            if (bus_req === 1'b1) begin
                if (cur_len > 0 && {bus_we, bus_addr, bus_wdata} !== held) stab_err++;
                held = {bus_we, bus_addr, bus_wdata};
                cur_len++;
                req_total++;
                if ((ack_delay != 0 && cur_len == ack_delay) || force_ack) begin
                    resp_ack   = 1'b1;
                    resp_rdata = slave_mem.exists(bus_addr) ? slave_mem[bus_addr] : mem_init(bus_addr);
                    if (bus_we) slave_mem[bus_addr] = bus_wdata;
                    bus_log.push_back({bus_we, bus_addr, bus_wdata});
                end
            end else begin
                if (cur_len > 0) last_len = cur_len;
                cur_len = 0;
            end
        end
    end

    // reference model: whole command in, expected response and bus access out
    logic [15:0] model_mem [logic [15:0]];

    task automatic model_cmd(input byte_q_t cmd, output byte_q_t rsp, output bit has_bus,
                             output logic [32:0] op);
        logic [15:0] a, d;
        rsp.delete();
        has_bus = 0;
        op = '0;
        case (cmd[0])
            8'h01: begin
                a = {cmd[1], cmd[2]};
                d = {cmd[3], cmd[4]};
                model_mem[a] = d;
                has_bus = 1;
                op = {1'b1, a, d};
                rsp.push_back(8'hA5);
            end
            8'h02: begin
                a = {cmd[1], cmd[2]};
                d = model_mem.exists(a) ? model_mem[a] : mem_init(a);
                has_bus = 1;
                op = {1'b0, a, 16'h0000};
                rsp.push_back(8'hA5);
                rsp.push_back(d[15:8]);
                rsp.push_back(d[7:0]);
            end
            8'h03:   rsp.push_back(8'hA5);
            default: rsp.push_back(8'hE1);
        endcase
    endtask

    // driver tasks; called and returning on a negative edge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        out_data  = b;
        out_valid = 1'b1;
        while (out_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("out_ready_timeout", 32'(out_ready), 32'd1);
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    task automatic recv_rsp(input int n_exp, input bit stall, output byte_q_t got);
        int n = 0;
        got.delete();
        while (got.size() < n_exp && n < 2000) begin
            in_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (in_valid === 1'b1 && in_ready) got.push_back(in_data);
            @(negedge clk);
            n++;
        end
        in_ready = 1'b0;
    endtask

    task automatic finish_checks(input string tag, input byte_q_t exp_q, input byte_q_t got,
                                 input bit has_bus, input logic [32:0] op, input int nb0, input int st0);
        logic [32:0] last;
        check({tag, ":rsp_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s:byte%0d", tag, i), got[i], exp_q[i]);
        check({tag, ":in_valid_idle"}, 32'(in_valid), 32'd0);
        check({tag, ":out_ready_idle"}, 32'(out_ready), 32'd1);
        check({tag, ":bus_count"}, bus_log.size() - nb0, 32'(has_bus));
        if (has_bus && bus_log.size() > nb0) begin
            last = bus_log[bus_log.size() - 1];
            check({tag, ":bus_we"}, 32'(last[32]), 32'(op[32]));
            check({tag, ":bus_addr"}, 32'(last[31:16]), 32'(op[31:16]));
            if (op[32]) check({tag, ":bus_wdata"}, 32'(last[15:0]), 32'(op[15:0]));
        end
        check({tag, ":bus_stable"}, stab_err - st0, 32'd0);
    endtask

    task automatic run_cmd(input string tag, input byte_q_t cmd, input int delay, input bit stall);
        byte_q_t exp_q, got;
        bit has_bus;
        logic [32:0] op;
        int nb0, st0;
        model_cmd(cmd, exp_q, has_bus, op);
        nb0 = bus_log.size();
        st0 = stab_err;
        ack_delay = delay;
        foreach (cmd[i]) send_byte(cmd[i]);
        recv_rsp(exp_q.size(), stall, got);
        finish_checks(tag, exp_q, got, has_bus, op, nb0, st0);
    endtask

    initial begin
        byte_q_t c, exp_q, got;
        bit has_bus;
        logic [32:0] op;
        int hi, n, nb0, st0, rt0, sel;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_out_ready", 32'(out_ready), 32'd0);
        check("rst_in_valid", 32'(in_valid), 32'd0);
        check("rst_in_data", 32'(in_data), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // write 0x1234 <- 0xBEEF, ack after 3 request cycles
        c = '{8'h01, 8'h12, 8'h34, 8'hBE, 8'hEF};
        run_cmd("t1_write", c, 3, 1'b0);
        check("t1_req_len", last_len, 32'd3);

        // read 0x0010 returning 0xCAFE
        slave_mem[16'h0010] = 16'hCAFE;
        model_mem[16'h0010] = 16'hCAFE;
        c = '{8'h02, 8'h00, 8'h10};
        run_cmd("t2_read", c, 1, 1'b0);

        // ping and bad opcode never touch the bus; stray ack while idle is ignored
        rt0 = req_total;
        spur_ack = 1'b1;
        repeat (2) @(negedge clk);
        spur_ack = 1'b0;
        c = '{8'h03};
        run_cmd("t3_ping", c, 1, 1'b0);
        c = '{8'h7F};
        run_cmd("t3_badop", c, 1, 1'b0);
        check("t3_no_req", req_total - rt0, 32'd0);

        // response held under back-pressure
        c = '{8'h02, 8'h00, 8'h20};
        model_cmd(c, exp_q, has_bus, op);
        nb0 = bus_log.size();
        st0 = stab_err;
        ack_delay = 1;
        foreach (c[i]) send_byte(c[i]);
        n = 0;
        while (in_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        repeat (20) begin
            if (in_valid === 1'b1 && in_data === 8'hA5 && out_ready === 1'b0) hi++;
            @(negedge clk);
        end
        check("t4_stall_hold", hi, 32'd20);
        recv_rsp(exp_q.size(), 1'b0, got);
        finish_checks("t4_read", exp_q, got, has_bus, op, nb0, st0);

        // bus access with no ack
        c = '{8'h02, 8'h00, 8'h40};
        nb0 = bus_log.size();
        st0 = stab_err;
        ack_delay = 0;
        force_ack = 0;
        foreach (c[i]) send_byte(c[i]);
        hi = 0;
        repeat (40) begin
            if (bus_req === 1'b1) hi++;
            @(negedge clk);
        end
`ifdef BRIDGE_TIMEOUT_EN
        check("t5_req_len", hi, 32'd16);
        exp_q = '{8'hEE};
        recv_rsp(exp_q.size(), 1'b0, got);
        finish_checks("t5_timeout", exp_q, got, 1'b0, 33'h0, nb0, st0);
`else
        check("t5_req_held", hi, 32'd40);
        model_cmd(c, exp_q, has_bus, op);
        force_ack = 1;
        recv_rsp(exp_q.size(), 1'b0, got);
        force_ack = 0;
        finish_checks("t5_late_ack", exp_q, got, has_bus, op, nb0, st0);
`endif

        // reset mid-command discards the partial write
        nb0 = bus_log.size();
        send_byte(8'h01);
        send_byte(8'h12);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_out_ready", 32'(out_ready), 32'd0);
        check("t6_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        c = '{8'h03};
        run_cmd("t6_ping", c, 1, 1'b0);
        check("t6_no_bus", bus_log.size() - nb0, 32'd0);

        // reset during BUS drops the request at once
        ack_delay = 0;
        c = '{8'h02, 8'h00, 8'h05};
        foreach (c[i]) send_byte(c[i]);
        repeat (3) @(negedge clk);
        check("t6b_req_before", 32'(bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6b_req_async", 32'(bus_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // reset during a stalled response drops in_valid at once
        send_byte(8'h03);
        repeat (2) @(negedge clk);
        check("t6c_valid_before", 32'(in_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6c_valid_async", 32'(in_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // random command stream
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            c.delete();
            if (sel <= 2)      c.push_back(8'h01);
            else if (sel <= 5) c.push_back(8'h02);
            else if (sel == 6) c.push_back(8'h03);
            else               c.push_back(8'($urandom_range(4, 255)));
            if (c[0] == 8'h01 || c[0] == 8'h02) begin
                c.push_back(8'h00);
                c.push_back(8'($urandom_range(0, 7)));
            end
            if (c[0] == 8'h01) begin
                c.push_back(8'($urandom));
                c.push_back(8'($urandom));
            end
            run_cmd($sformatf("rnd%0d", k), c, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
